// File: rtl/ptw_arb_pkg.sv
// Shared types and constants for the page-table-walker request arbiter.
// Holds the FSM state encoding, the packed PTE field layout and the request bundle.
package ptw_arb_pkg;

  // Request and PTE geometry
  localparam int ADDR_W = 27;
  localparam int PPN_W  = 38;
  localparam int PTE_W  = 64;

  // PTE field offsets: {rsv_hw[15:0], ppn[37:0], rsv_sw[1:0], d, a, g, u, x, w, r, v}
  localparam int PTE_V          = 0;
  localparam int PTE_R          = 1;
  localparam int PTE_W_BIT      = 2;
  localparam int PTE_X          = 3;
  localparam int PTE_U          = 4;
  localparam int PTE_G          = 5;
  localparam int PTE_A          = 6;
  localparam int PTE_D          = 7;
  localparam int PTE_RSV_SW_LSB = 8;
  localparam int PTE_RSV_SW_W   = 2;
  localparam int PTE_PPN_LSB    = 10;
  localparam int PTE_PPN_W      = PPN_W;
  localparam int PTE_RSV_HW_LSB = 48;
  localparam int PTE_RSV_HW_W   = 16;

  // Arbiter walk-ownership states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Fields of one translation request, latched as a unit on accept
  typedef struct packed {
    logic [1:0]        prv;
    logic              pum;
    logic              mxr;
    logic              store;
    logic              fetch;
    logic [ADDR_W-1:0] addr;
  } ptw_req_t;

endpackage

// File: rtl/ptw_arb_grant.sv
// Two-way grant selection between the ITLB (0) and DTLB (1) requestors.
// Build option PTW_ARB_ROUND_ROBIN_EN: when defined, ties alternate using the
// last-served requestor; when undefined, requestor 0 wins every tie.
module ptw_arb_grant (
`ifdef PTW_ARB_ROUND_ROBIN_EN
  input  logic       last,
`endif
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  // A lone valid requestor always wins; only a tie needs a policy decision
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
`ifdef PTW_ARB_ROUND_ROBIN_EN
      grant = last ? 2'b01 : 2'b10;
`else
      grant = 2'b01;
`endif
    end
  end

endmodule

// File: rtl/ptw_req_arbiter.sv
// Shares one page-table walker between the ITLB (0) and DTLB (1).
// Accepts one request at a time, presents it to the PTW, and steers the single
// response back to the requestor that owns the walk. Only one walk is ever in flight.
// Build option PTW_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// (default build: fixed priority to requestor 0).
module ptw_req_arbiter
  import ptw_arb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_prv,
  input  logic              req0_pum,
  input  logic              req0_mxr,
  input  logic              req0_store,
  input  logic              req0_fetch,
  input  logic [ADDR_W-1:0] req0_addr,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_prv,
  input  logic              req1_pum,
  input  logic              req1_mxr,
  input  logic              req1_store,
  input  logic              req1_fetch,
  input  logic [ADDR_W-1:0] req1_addr,

  output logic              ptw_req_valid,
  input  logic              ptw_req_ready,
  output logic [1:0]        ptw_req_prv,
  output logic              ptw_req_pum,
  output logic              ptw_req_mxr,
  output logic [ADDR_W-1:0] ptw_req_addr,
  output logic              ptw_req_store,
  output logic              ptw_req_fetch,

  input  logic              ptw_resp_valid,
  input  logic [PTE_W-1:0]  ptw_resp_pte,

  output logic              resp0_valid,
  output logic              resp1_valid,
  output logic [PTE_W-1:0]  resp_pte,
  output logic              busy,
  output logic              err_stray_resp
);

  state_e             state_q, state_d;
  ptw_req_t           req_q, req_d;
  ptw_req_t           req0_bundle, req1_bundle;
  logic               dest_q, dest_d;
  logic [PTE_W-1:0]   resp_pte_q, resp_pte_d;
  logic               err_q, err_d;
  logic [1:0]         grant;
`ifdef PTW_ARB_ROUND_ROBIN_EN
  logic               last_q, last_d;
`endif

  assign req0_bundle = '{prv: req0_prv, pum: req0_pum, mxr: req0_mxr,
                         store: req0_store, fetch: req0_fetch, addr: req0_addr};
  assign req1_bundle = '{prv: req1_prv, pum: req1_pum, mxr: req1_mxr,
                         store: req1_store, fetch: req1_fetch, addr: req1_addr};

  ptw_arb_grant u_grant (
`ifdef PTW_ARB_ROUND_ROBIN_EN
    .last  (last_q),
`endif
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  // State register plus latched request, owner, response PTE and sticky error
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= '0;
      dest_q     <= 1'b0;
      resp_pte_q <= '0;
      err_q      <= 1'b0;
`ifdef PTW_ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      dest_q     <= dest_d;
      resp_pte_q <= resp_pte_d;
      err_q      <= err_d;
`ifdef PTW_ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  // Next state: accept in IDLE, hand off in SEND, capture the PTE in WAIT, deliver in RESP
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    dest_d     = dest_q;
    resp_pte_d = resp_pte_q;
    err_d      = err_q;
`ifdef PTW_ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    if (ptw_resp_valid && (state_q != WAIT)) begin
      err_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          req_d   = grant[1] ? req1_bundle : req0_bundle;
          dest_d  = grant[1];
          state_d = SEND;
        end
      end
      SEND: begin
        if (ptw_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ptw_resp_valid) begin
          resp_pte_d = ptw_resp_pte;
          state_d    = RESP;
        end
      end
      RESP: begin
`ifdef PTW_ARB_ROUND_ROBIN_EN
        last_d  = dest_q;
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from state; readies are held low while reset is asserted
  always_comb begin
    req0_ready     = reset && (state_q == IDLE) && grant[0];
    req1_ready     = reset && (state_q == IDLE) && grant[1];
    ptw_req_valid  = (state_q == SEND);
    ptw_req_prv    = req_q.prv;
    ptw_req_pum    = req_q.pum;
    ptw_req_mxr    = req_q.mxr;
    ptw_req_addr   = req_q.addr;
    ptw_req_store  = req_q.store;
    ptw_req_fetch  = req_q.fetch;
    resp0_valid    = (state_q == RESP) && !dest_q;
    resp1_valid    = (state_q == RESP) && dest_q;
    resp_pte       = resp_pte_q;
    busy           = (state_q != IDLE);
    err_stray_resp = err_q;
  end

endmodule
